// File: rtl/mandelbrot_pkg.sv
// Shared geometry, FIFO word layout and unpack helper for the pixel back end.
package mandelbrot_pkg;

  localparam int X_WIDTH    = 10;
  localparam int ITER_WIDTH = 10;
  localparam int DATA_WIDTH = X_WIDTH + ITER_WIDTH;
  localparam int LINE_WIDTH = 640;
  localparam int NUM_LINES  = 480;
  localparam int Y_WIDTH    = $clog2(NUM_LINES);

  localparam logic [X_WIDTH-1:0] LAST_X = X_WIDTH'(LINE_WIDTH - 1);
  localparam logic [Y_WIDTH-1:0] LAST_Y = Y_WIDTH'(NUM_LINES - 1);

  // x occupies the upper bits of a FIFO word, depth the lower bits
  typedef struct packed {
    logic [X_WIDTH-1:0]    x;
    logic [ITER_WIDTH-1:0] depth;
  } pixel_result_t;

  function automatic pixel_result_t unpack_result(input logic [DATA_WIDTH-1:0] word);
    pixel_result_t r;
    r.x     = word[DATA_WIDTH-1:ITER_WIDTH];
    r.depth = word[ITER_WIDTH-1:0];
    return r;
  endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// One line of iteration depths: synchronous write, combinational read (LUT RAM).
module line_buffer_ram
  import mandelbrot_pkg::*;
(
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [X_WIDTH-1:0]    i_wr_addr,
  input  logic [ITER_WIDTH-1:0] i_wr_data,
  input  logic [X_WIDTH-1:0]    i_rd_addr,
  output logic [ITER_WIDTH-1:0] o_rd_data
);

  logic [ITER_WIDTH-1:0] r_mem [LINE_WIDTH];

  // Write port; storage carries no reset, slot validity lives in the top level
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/pixel_reorder_stream.sv
// Reorders out-of-x-order {x, depth} results into a raster AXI-Stream of depths.
// A word arriving for a slot that still holds an unemitted pixel (next line
// overtaking the current one) parks in a one-entry hold register and retries.
module pixel_reorder_stream
  import mandelbrot_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  output logic                  fifo_read_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic [ITER_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  err_x_range
);

  logic [LINE_WIDTH-1:0] r_valid;
  logic                  r_pending;
  logic                  r_hold_valid;
  pixel_result_t         r_hold;
  logic [X_WIDTH-1:0]    r_out_x;
  logic [Y_WIDTH-1:0]    r_out_y;
  logic                  r_err;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic                  r_tuser;
  logic [ITER_WIDTH-1:0] r_tdata;

  pixel_result_t         w_arr;
  logic                  w_arr_valid;
  logic                  w_in_range;
  logic                  w_slot_busy;
  logic                  w_collide;
  logic                  w_wr_en;
  logic                  w_emit;
  logic [ITER_WIDTH-1:0] w_rd_depth;

  // The hold register takes priority; it and pending are never both set
  assign w_arr       = r_hold_valid ? r_hold : unpack_result(fifo_data);
  assign w_arr_valid = r_hold_valid | r_pending;
  assign w_in_range  = (w_arr.x <= LAST_X);
  assign w_slot_busy = w_in_range && r_valid[w_arr.x];
  assign w_collide   = w_arr_valid && w_slot_busy;
  assign w_wr_en     = w_arr_valid && w_in_range && !r_valid[w_arr.x];

  // A colliding word in flight means the next pop would have nowhere to go
  assign fifo_read_en = !reset && !fifo_empty && !r_hold_valid && !(r_pending && w_collide);

  assign w_emit = r_valid[r_out_x] && (!r_tvalid || m_axis_tready);

  line_buffer_ram u_line_buffer_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_arr.x),
    .i_wr_data (w_arr.depth),
    .i_rd_addr (r_out_x),
    .o_rd_data (w_rd_depth)
  );

  // Pop tracking, hold register load/retry/drain and the sticky range error
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending    <= 1'b0;
      r_hold_valid <= 1'b0;
      r_hold       <= '0;
      r_err        <= 1'b0;
    end else begin
      r_pending    <= fifo_read_en;
      r_hold_valid <= w_collide;
      if (w_collide) begin
        r_hold <= w_arr;
      end
      if (w_arr_valid && !w_in_range) begin
        r_err <= 1'b1;
      end
    end
  end

  // Slot valid bits: set on write, cleared on emit (never the same slot in one cycle)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
    end else begin
      if (w_emit) begin
        r_valid[r_out_x] <= 1'b0;
      end
      if (w_wr_en) begin
        r_valid[w_arr.x] <= 1'b1;
      end
    end
  end

  // Output register and raster position; holds still while the sink stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tlast  <= 1'b0;
      r_tuser  <= 1'b0;
      r_out_x  <= '0;
      r_out_y  <= '0;
    end else if (w_emit) begin
      r_tvalid <= 1'b1;
      r_tdata  <= w_rd_depth;
      r_tlast  <= (r_out_x == LAST_X);
      r_tuser  <= (r_out_x == '0) && (r_out_y == '0);
      if (r_out_x == LAST_X) begin
        r_out_x <= '0;
        r_out_y <= (r_out_y == LAST_Y) ? '0 : r_out_y + Y_WIDTH'(1);
      end else begin
        r_out_x <= r_out_x + X_WIDTH'(1);
      end
    end else if (m_axis_tready) begin
      r_tvalid <= 1'b0;
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = r_tuser;
  assign err_x_range   = r_err;

endmodule
